// File: rtl/dice_pkg.sv
// Shared definitions for the dice roll control path and the dice counter stage.
package dice_pkg;

  // Roll controller state encoding
  localparam int unsigned STATE_W = 2;
  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_SPIN = 2'd1;
  localparam logic [STATE_W-1:0] ST_SLOW = 2'd2;
  localparam logic [STATE_W-1:0] ST_DONE = 2'd3;

  // Default tuning of the roll controller
  localparam int unsigned DEF_DEB_CYCLES = 4;
  localparam int unsigned DEF_SLOW_STEPS = 5;
  localparam int unsigned DEF_BASE_GAP   = 2;
  localparam int unsigned DEF_GAP_INC    = 2;
  localparam int unsigned DEF_CNT_W      = 8;

  // Face range of the dice counter fed by the advance strobe
  localparam int unsigned DICE_FACE_MIN = 1;
  localparam int unsigned DICE_FACE_MAX = 6;

  // Longest low gap of the slow-down sequence (gap before the final pulse)
  function automatic int unsigned slow_last_gap(input int unsigned base_gap,
                                                input int unsigned gap_inc,
                                                input int unsigned slow_steps);
    return base_gap + (slow_steps - 1) * gap_inc;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a stable-sample debounce filter.
module btn_debounce
  import dice_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic clk,
  input  logic res,
  input  logic btn,
  output logic btn_db
);

  logic             sync1_q;
  logic             sync2_q;
  logic             db_q;
  logic             db_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Bring the raw button level into the clk domain
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive disagreeing samples; flip the held level once enough agree
  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_W'(DEB_CYCLES)) begin
        db_d  = ~db_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Debounce state
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      cnt_q <= '0;
      db_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      db_q  <= db_d;
    end
  end

  assign btn_db = db_q;

endmodule

// File: rtl/dice_roll_ctrl.sv
// Turns a bouncy push-button into the dice advance strobe: spin while held,
// a progressively slower pulse train after release, then a done pulse.
module dice_roll_ctrl
  import dice_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int unsigned SLOW_STEPS = DEF_SLOW_STEPS,
  parameter int unsigned BASE_GAP   = DEF_BASE_GAP,
  parameter int unsigned GAP_INC    = DEF_GAP_INC,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic clk,
  input  logic res,
  input  logic btn,
  output logic s,
  output logic rolling,
  output logic done
);

  localparam int unsigned STEP_W  = $clog2(SLOW_STEPS + 1);
  localparam int unsigned MAX_GAP = slow_last_gap(BASE_GAP, GAP_INC, SLOW_STEPS);

  // Reject configurations whose gaps or debounce count do not fit the counters
  if (DEB_CYCLES < 1 || SLOW_STEPS < 1 || BASE_GAP < 1 ||
      MAX_GAP >= (64'd1 << CNT_W) || DEB_CYCLES >= (64'd1 << CNT_W)) begin : g_bad_params
    $error("dice_roll_ctrl: parameter set does not fit CNT_W or is out of range");
  end

  logic               btn_db;
  logic               db_prev_q;
  logic               db_rise;

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  logic               s_q;
  logic               s_d;
  logic               rolling_q;
  logic               rolling_d;
  logic               done_q;
  logic               done_d;
  logic [CNT_W-1:0]   gap_q;
  logic [CNT_W-1:0]   gap_d;
  logic [CNT_W-1:0]   gap_cnt_q;
  logic [CNT_W-1:0]   gap_cnt_d;
  logic [STEP_W-1:0]  steps_q;
  logic [STEP_W-1:0]  steps_d;

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES),
    .CNT_W      (CNT_W)
  ) u_btn_debounce (
    .clk    (clk),
    .res    (res),
    .btn    (btn),
    .btn_db (btn_db)
  );

  // A roll only starts on a fresh press, never on a level still held
  assign db_rise = btn_db & ~db_prev_q;

  // Next state, next outputs and slow-down bookkeeping
  always_comb begin
    state_d   = state_q;
    s_d       = 1'b0;
    rolling_d = 1'b0;
    done_d    = 1'b0;
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt_q;
    steps_d   = steps_q;

    case (state_q)
      ST_IDLE: begin
        if (db_rise) begin
          state_d   = ST_SPIN;
          s_d       = 1'b1;
          rolling_d = 1'b1;
        end
      end

      ST_SPIN: begin
        rolling_d = 1'b1;
        if (!btn_db) begin
          // Release: first low cycle of the slow-down starts on this edge
          state_d   = ST_SLOW;
          gap_d     = CNT_W'(BASE_GAP);
          gap_cnt_d = '0;
          steps_d   = '0;
        end else begin
          s_d = 1'b1;
        end
      end

      ST_SLOW: begin
        rolling_d = 1'b1;
        if (db_rise) begin
          // Re-press wins over any pulse due on the same edge
          state_d = ST_SPIN;
          s_d     = 1'b1;
        end else if (steps_q == STEP_W'(SLOW_STEPS)) begin
          state_d   = ST_DONE;
          rolling_d = 1'b0;
          done_d    = 1'b1;
        end else if (!s_q) begin
          // gap_cnt counts low cycles already completed before the current one
          if ((gap_cnt_q + CNT_W'(1)) == gap_q) begin
            s_d       = 1'b1;
            steps_d   = steps_q + STEP_W'(1);
            gap_d     = gap_q + CNT_W'(GAP_INC);
            gap_cnt_d = '0;
          end else begin
            gap_cnt_d = gap_cnt_q + CNT_W'(1);
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Registered outputs, edge-detect history and slow-down counters
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      db_prev_q <= 1'b0;
      s_q       <= 1'b0;
      rolling_q <= 1'b0;
      done_q    <= 1'b0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
      steps_q   <= '0;
    end else begin
      db_prev_q <= btn_db;
      s_q       <= s_d;
      rolling_q <= rolling_d;
      done_q    <= done_d;
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
      steps_q   <= steps_d;
    end
  end

  assign s       = s_q;
  assign rolling = rolling_q;
  assign done    = done_q;

endmodule

// File: tb/tb_dice_roll_ctrl.sv
// Self-checking bench for dice_roll_ctrl against a schedule-based reference model.
module tb_dice_roll_ctrl;
  import dice_pkg::*;

  localparam int DEB  = int'(DEF_DEB_CYCLES);
  localparam int N    = int'(DEF_SLOW_STEPS);
  localparam int BASE = int'(DEF_BASE_GAP);
  localparam int INC  = int'(DEF_GAP_INC);

  logic clk;
  logic res;
  logic btn;
  logic s;
  logic rolling;
  logic done;

  int checks = 0;
  int errors = 0;

  bit wave[$];
  bit exp_s[$];
  bit exp_r[$];
  bit exp_d[$];
  int pulse_off[N];
  int done_off;

  dice_roll_ctrl dut (
    .clk     (clk),
    .res     (res),
    .btn     (btn),
    .s       (s),
    .rolling (rolling),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
    $fatal(1);
  end

  // Offsets (from the slow-down entry edge) of every pulse: lows of gap_i then one high
  function automatic void build_schedule();
    int acc;
    acc = 0;
    for (int i = 0; i < N; i++) begin
      acc += BASE + i * INC;
      pulse_off[i] = acc + i;
    end
    done_off = pulse_off[N-1] + 1;
  endfunction

  function automatic bit is_pulse(input int off);
    for (int i = 0; i < N; i++) if (pulse_off[i] == off) return 1'b1;
    return 1'b0;
  endfunction

  // Expected s/rolling/done per edge for the btn sequence in wave (idle, settled start)
  function automatic void build_expect();
    int n, e, len, mode, entry, off;
    bit cur, d1, d2, rise, bs, br, bd;
    bit db[];
    n  = wave.size();
    db = new[n];
    cur = 1'b0;
    e   = 0;
    // Level runs longer than the debounce count flip the clean level DEB+2 edges later
    while (e < n) begin
      len = 1;
      while (e + len < n && wave[e+len] == wave[e]) len++;
      if (wave[e] != cur && len >= DEB + 1) begin
        cur = wave[e];
        for (int j = e + DEB + 2; j < n; j++) db[j] = cur;
      end
      e += len;
    end
    exp_s.delete(); exp_r.delete(); exp_d.delete();
    mode = 0; entry = 0;
    for (int k = 0; k < n; k++) begin
      d1 = (k >= 1) ? db[k-1] : 1'b0;
      d2 = (k >= 2) ? db[k-2] : 1'b0;
      rise = d1 & ~d2;
      bs = 1'b0; br = 1'b0; bd = 1'b0;
      case (mode)
        0: if (rise) begin mode = 1; bs = 1'b1; br = 1'b1; end
        1: begin
          br = 1'b1;
          if (!d1) begin mode = 2; entry = k; end
          else bs = 1'b1;
        end
        2: begin
          off = k - entry;
          if (rise) begin mode = 1; bs = 1'b1; br = 1'b1; end
          else if (off == done_off) begin mode = 3; bd = 1'b1; end
          else begin bs = is_pulse(off); br = 1'b1; end
        end
        default: mode = 0;
      endcase
      exp_s.push_back(bs); exp_r.push_back(br); exp_d.push_back(bd);
    end
  endfunction

  task automatic test_reset();
    int hold, first_s;
    res = 1'b0; btn = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      checks++;
      if ({s, rolling, done} !== 3'b000) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d: s/rolling/done=%b%b%b, required 000", k, s, rolling, done);
      end
    end
    // Button still held when reset lifts: it must debounce in as a fresh press
    hold = int'($urandom_range(12, 25));
    wave.delete();
    for (int k = 0; k < hold; k++) wave.push_back(1'b1);
    for (int k = 0; k < 60; k++) wave.push_back(1'b0);
    build_expect();
    @(negedge clk); res = 1'b1;
    first_s = -1;
    for (int k = 0; k < wave.size(); k++) begin
      btn = wave[k];
      @(posedge clk); #1;
      if (s === 1'b1 && first_s < 0) first_s = k;
      checks++;
      if ({s, rolling, done} !== {exp_s[k], exp_r[k], exp_d[k]}) begin
        errors++;
        $display("FAIL reset_release k=%0d: s/rolling/done=%b%b%b, required %b%b%b",
                 k, s, rolling, done, exp_s[k], exp_r[k], exp_d[k]);
      end
    end
    checks++;
    if (first_s !== DEB + 3) begin
      errors++;
      $display("FAIL first_strobe_edge: got %0d, required %0d", first_s, DEB + 3);
    end
  endtask

  task automatic test_glitch();
    int w, seen;
    for (int it = 0; it < 4; it++) begin
      w = (it == 0) ? 3 : int'($urandom_range(1, DEB));
      wave.delete();
      for (int k = 0; k < 5; k++) wave.push_back(1'b0);
      for (int k = 0; k < w; k++) wave.push_back(1'b1);
      for (int k = 0; k < 20; k++) wave.push_back(1'b0);
      build_expect();
      seen = 0;
      for (int k = 0; k < wave.size(); k++) begin
        btn = wave[k];
        @(posedge clk); #1;
        if (s === 1'b1 || rolling === 1'b1) seen++;
        checks++;
        if ({s, rolling, done} !== {exp_s[k], exp_r[k], exp_d[k]}) begin
          errors++;
          $display("FAIL glitch w=%0d k=%0d: s/rolling/done=%b%b%b, required %b%b%b",
                   w, k, s, rolling, done, exp_s[k], exp_r[k], exp_d[k]);
        end
      end
      checks++;
      if (seen !== 0) begin
        errors++;
        $display("FAIL glitch_start w=%0d: active cycles %0d, required 0", w, seen);
      end
    end
  endtask

  task automatic test_spin_slow();
    int hold, done_idx, ndone, idx, run;
    bit obs_s[$];
    for (int it = 0; it < 3; it++) begin
      hold = (it == 0) ? 27 : int'($urandom_range(10, 40));
      wave.delete();
      for (int k = 0; k < hold; k++) wave.push_back(1'b1);
      for (int k = 0; k < 60; k++) wave.push_back(1'b0);
      build_expect();
      obs_s.delete();
      done_idx = -1; ndone = 0;
      for (int k = 0; k < wave.size(); k++) begin
        btn = wave[k];
        @(posedge clk); #1;
        obs_s.push_back(s);
        if (done === 1'b1) begin ndone++; if (done_idx < 0) done_idx = k; end
        checks++;
        if ({s, rolling, done} !== {exp_s[k], exp_r[k], exp_d[k]}) begin
          errors++;
          $display("FAIL spin_slow hold=%0d k=%0d: s/rolling/done=%b%b%b, required %b%b%b",
                   hold, k, s, rolling, done, exp_s[k], exp_r[k], exp_d[k]);
        end
      end
      checks++;
      if (ndone !== 1) begin
        errors++;
        $display("FAIL done_count hold=%0d: got %0d, required 1", hold, ndone);
      end
      // Walk back from done: single-cycle pulses separated by growing low runs
      if (done_idx > 0) begin
        idx = done_idx - 1;
        for (int i = N - 1; i >= 0; i--) begin
          checks++;
          if (idx < 0 || obs_s[idx] !== 1'b1) begin
            errors++;
            $display("FAIL slow_pulse %0d: pulse missing before index %0d, required s=1", i + 1, idx);
          end
          idx--;
          run = 0;
          while (idx >= 0 && obs_s[idx] == 1'b0) begin run++; idx--; end
          checks++;
          if (run !== BASE + i * INC) begin
            errors++;
            $display("FAIL slow_gap %0d: got %0d low cycles, required %0d", i + 1, run, BASE + i * INC);
          end
        end
      end
    end
  endtask

  task automatic test_repress();
    int h1, h2, o;
    for (int it = 0; it < 4; it++) begin
      h1 = int'($urandom_range(10, 20));
      h2 = int'($urandom_range(10, 20));
      o  = (it == 0) ? pulse_off[1] + 1 : (it == 1) ? done_off : int'($urandom_range(DEB + 1, done_off));
      wave.delete();
      for (int k = 0; k < h1; k++) wave.push_back(1'b1);
      for (int k = 0; k < o; k++)  wave.push_back(1'b0);
      for (int k = 0; k < h2; k++) wave.push_back(1'b1);
      for (int k = 0; k < 60; k++) wave.push_back(1'b0);
      build_expect();
      for (int k = 0; k < wave.size(); k++) begin
        btn = wave[k];
        @(posedge clk); #1;
        checks++;
        if ({s, rolling, done} !== {exp_s[k], exp_r[k], exp_d[k]}) begin
          errors++;
          $display("FAIL repress o=%0d k=%0d: s/rolling/done=%b%b%b, required %b%b%b",
                   o, k, s, rolling, done, exp_s[k], exp_r[k], exp_d[k]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int h1, h2, z;
    for (int it = 0; it < 4; it++) begin
      h1 = int'($urandom_range(10, 20));
      h2 = int'($urandom_range(10, 20));
      z  = (it < 3) ? done_off + it : done_off + int'($urandom_range(3, 8));
      wave.delete();
      for (int k = 0; k < h1; k++) wave.push_back(1'b1);
      for (int k = 0; k < z; k++)  wave.push_back(1'b0);
      for (int k = 0; k < h2; k++) wave.push_back(1'b1);
      for (int k = 0; k < 60; k++) wave.push_back(1'b0);
      build_expect();
      for (int k = 0; k < wave.size(); k++) begin
        btn = wave[k];
        @(posedge clk); #1;
        checks++;
        if ({s, rolling, done} !== {exp_s[k], exp_r[k], exp_d[k]}) begin
          errors++;
          $display("FAIL back_to_back z=%0d k=%0d: s/rolling/done=%b%b%b, required %b%b%b",
                   z, k, s, rolling, done, exp_s[k], exp_r[k], exp_d[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int hold, k_stop;
    hold = int'($urandom_range(10, 20));
    wave.delete();
    for (int k = 0; k < hold; k++) wave.push_back(1'b1);
    for (int k = 0; k < 60; k++) wave.push_back(1'b0);
    build_expect();
    // Stop on the first slow-down pulse so the strobe is high when reset hits
    k_stop = hold + DEB + 3 + BASE;
    for (int k = 0; k <= k_stop; k++) begin
      btn = wave[k];
      @(posedge clk); #1;
      checks++;
      if ({s, rolling, done} !== {exp_s[k], exp_r[k], exp_d[k]}) begin
        errors++;
        $display("FAIL pre_reset k=%0d: s/rolling/done=%b%b%b, required %b%b%b",
                 k, s, rolling, done, exp_s[k], exp_r[k], exp_d[k]);
      end
    end
    #2;
    res = 1'b0;
    #1;
    checks++;
    if ({s, rolling, done} !== 3'b000) begin
      errors++;
      $display("FAIL async_reset: s/rolling/done=%b%b%b, required 000", s, rolling, done);
    end
    btn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); res = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      checks++;
      if ({s, rolling, done} !== 3'b000) begin
        errors++;
        $display("FAIL post_reset_idle cyc=%0d: s/rolling/done=%b%b%b, required 000", k, s, rolling, done);
      end
    end
  endtask

  initial begin
    res = 1'b0;
    btn = 1'b0;
    build_schedule();
    test_reset();
    test_glitch();
    test_spin_slow();
    test_repress();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
